// File: rtl/ysyx_040978_mdu_pkg.sv
// Shared MDU definitions: divider FSM encoding, default width
// and the two operand constants the divider's special cases test for.
package ysyx_040978_mdu_pkg;

   localparam int MDU_XLEN = 64;
   localparam int MDU_CNT_W = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam logic [MDU_XLEN-1:0] INT_MIN  = {1'b1, {(MDU_XLEN-1){1'b0}}};
   localparam logic [MDU_XLEN-1:0] ALL_ONES = {MDU_XLEN{1'b1}};

endpackage

// File: rtl/ysyx_040978_abs_neg.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of quotient and remainder.
module ysyx_040978_abs_neg #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic         neg_i,
   output logic [W-1:0] y_o
);

   always_comb begin
      y_o = a_i;
      if (neg_i) y_o = ~a_i + {{(W-1){1'b0}}, 1'b1};
   end

endmodule

// File: rtl/ysyx_040978_div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle,
// RISC-V divide-by-zero and overflow results produced directly.
module ysyx_040978_div_iter
   import ysyx_040978_mdu_pkg::*;
#(
   parameter int XLEN  = MDU_XLEN,
   parameter int CNT_W = MDU_CNT_W
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            div_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            in_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   div_state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [XLEN-1:0]  resq_q, resq_d;
   logic [XLEN-1:0]  resr_q, resr_d;

   logic            accept;
   logic            div_zero;
   logic            ovf;
   logic            special;
   logic            last;
   logic [XLEN-1:0] dvd_abs;
   logic [XLEN-1:0] dvs_abs;
   logic [XLEN:0]   sh;
   logic [XLEN+1:0] diff;
   logic            ge;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   assign accept   = in_valid && (state_q == IDLE) && !flush;
   assign div_zero = (divisor == '0);
   assign ovf      = div_signed && (dividend == SMIN) && (divisor == ONES);
   assign special  = div_zero || ovf;
   assign last     = (cnt_q == CNT_ONE);

   ysyx_040978_abs_neg #(.W(XLEN)) u_abs_dvd (
      .a_i   (dividend),
      .neg_i (div_signed & dividend[XLEN-1]),
      .y_o   (dvd_abs)
   );

   ysyx_040978_abs_neg #(.W(XLEN)) u_abs_dvs (
      .a_i   (divisor),
      .neg_i (div_signed & divisor[XLEN-1]),
      .y_o   (dvs_abs)
   );

   // Partial remainder is XLEN+1 wide after the shift; a trial result
   // is kept only when it is non-negative, i.e. fits back in XLEN bits.
   assign sh     = {rem_q, quo_q[XLEN-1]};
   assign diff   = {1'b0, sh} - {2'b00, dvs_q};
   assign ge     = (diff[XLEN+1:XLEN] == 2'b00);
   assign rem_nx = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
   assign quo_nx = {quo_q[XLEN-2:0], ge};

   ysyx_040978_abs_neg #(.W(XLEN)) u_fix_quo (
      .a_i   (quo_nx),
      .neg_i (qneg_q),
      .y_o   (quo_fix)
   );

   ysyx_040978_abs_neg #(.W(XLEN)) u_fix_rem (
      .a_i   (rem_nx),
      .neg_i (rneg_q),
      .y_o   (rem_fix)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = special ? DONE : CALC;
         end
         CALC: begin
            if (flush) state_d = IDLE;
            else if (last) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE) && !flush;
      quotient  = resq_q;
      remainder = resr_q;
   end

   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      resq_d = resq_q;
      resr_d = resr_q;
      if (accept) begin
         if (special) begin
            resq_d = div_zero ? ONES : dividend;
            resr_d = div_zero ? dividend : '0;
         end else begin
            cnt_d  = CNT_INIT;
            rem_d  = '0;
            quo_d  = dvd_abs;
            dvs_d  = dvs_abs;
            qneg_d = div_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            rneg_d = div_signed & dividend[XLEN-1];
         end
      end else if ((state_q == CALC) && !flush) begin
         cnt_d = cnt_q - CNT_ONE;
         rem_d = rem_nx;
         quo_d = quo_nx;
         if (last) begin
            resq_d = quo_fix;
            resr_d = rem_fix;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         resq_q <= '0;
         resr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         resq_q <= resq_d;
         resr_q <= resr_d;
      end
   end

endmodule

// File: tb/tb_ysyx_040978_div_iter.sv
// Directed bench for the iterative divider: vector table plus
// flush, reset and back-to-back sequences.
module tb_ysyx_040978_div_iter;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        div_signed;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        flush;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] quotient;
   logic [63:0] remainder;

   int total;
   int bad;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

   typedef struct {
      string       nm;
      logic        sgn;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] q;
      logic [63:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   ysyx_040978_div_iter dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .flush      (flush),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_op(input string nm, input logic sgn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er,
                        input int elat);
      int lat;
      int w;
      w = 0;
      while (!in_ready && w < 200) begin
         step();
         w++;
      end
      in_valid   = 1'b1;
      div_signed = sgn;
      dividend   = a;
      divisor    = b;
      step();
      in_valid = 1'b0;
      dividend = 64'hDEAD_BEEF_DEAD_BEEF;
      divisor  = 64'h5;
      lat = 1;
      while (!out_valid && lat < 200) begin
         step();
         lat++;
      end
      chk({nm, " lat"}, 64'(lat), 64'(elat));
      chk({nm, " quo"}, quotient, eq);
      chk({nm, " rem"}, remainder, er);
      step();
      chk({nm, " pulse"}, {63'd0, out_valid}, 64'd0);
      chk({nm, " rdy"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      div_signed = 1'b0;
      dividend   = '0;
      divisor    = '0;
      flush      = 1'b0;

      vecs[0]  = '{"u100/7",   1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
      vecs[1]  = '{"s-7/2",    1'b1, -64'sd7, 64'd2, -64'sd3, -64'sd1, 65};
      vecs[2]  = '{"s7/-2",    1'b1, 64'd7, -64'sd2, -64'sd3, 64'd1, 65};
      vecs[3]  = '{"u/0",      1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1};
      vecs[4]  = '{"s/0",      1'b1, 64'h1234, 64'd0, ONES, 64'h1234, 1};
      vecs[5]  = '{"sovf",     1'b1, SMIN, ONES, SMIN, 64'd0, 1};
      vecs[6]  = '{"uovf",     1'b0, SMIN, ONES, 64'd0, SMIN, 65};
      vecs[7]  = '{"s-100/-7", 1'b1, -64'sd100, -64'sd7, 64'd14, -64'sd2, 65};
      vecs[8]  = '{"umax/1",   1'b0, ONES, 64'd1, ONES, 64'd0, 65};
      vecs[9]  = '{"u5/9",     1'b0, 64'd5, 64'd9, 64'd0, 64'd5, 65};
      vecs[10] = '{"smin/2",   1'b1, SMIN, 64'd2, 64'hC000_0000_0000_0000,
                   64'd0, 65};
      vecs[11] = '{"u9/3",     1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65};

      repeat (3) step();
      reset = 1'b0;
      chk("rst rdy", {63'd0, in_ready}, 64'd1);
      chk("rst ov", {63'd0, out_valid}, 64'd0);
      chk("rst quo", quotient, 64'd0);
      chk("rst rem", remainder, 64'd0);

      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].nm, vecs[i].sgn, vecs[i].a, vecs[i].b,
               vecs[i].q, vecs[i].r, vecs[i].lat);
      end

      // flush together with in_valid in IDLE must not accept
      in_valid = 1'b1;
      flush    = 1'b1;
      dividend = 64'd50;
      divisor  = 64'd5;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("idle flush rdy", {63'd0, in_ready}, 64'd1);

      // flush mid-CALC, with an ignored in_valid pulse at cycle 10
      begin
         int seen;
         seen       = 0;
         in_valid   = 1'b1;
         div_signed = 1'b0;
         dividend   = 64'd1000;
         divisor    = 64'd3;
         step();
         in_valid = 1'b0;
         for (int k = 1; k < 30; k++) begin
            if (k == 10) begin
               in_valid = 1'b1;
               dividend = 64'd77;
               divisor  = 64'd0;
            end else begin
               in_valid = 1'b0;
            end
            if (out_valid) seen++;
            step();
         end
         in_valid = 1'b0;
         flush    = 1'b1;
         if (out_valid) seen++;
         step();
         flush = 1'b0;
         chk("flush rdy", {63'd0, in_ready}, 64'd1);
         chk("flush quo", quotient, 64'd3);
         for (int k = 0; k < 70; k++) begin
            if (out_valid) seen++;
            step();
         end
         chk("flush noov", 64'(seen), 64'd0);
      end
      do_op("post flush 9/3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);

      // back-to-back with in_valid held high
      begin
         int lat;
         in_valid   = 1'b1;
         div_signed = 1'b0;
         dividend   = 64'd20;
         divisor    = 64'd4;
         step();
         lat = 1;
         while (!out_valid && lat < 200) begin
            step();
            lat++;
         end
         chk("b2b lat1", 64'(lat), 64'd65);
         chk("b2b quo1", quotient, 64'd5);
         chk("b2b rdy dn", {63'd0, in_ready}, 64'd0);
         dividend = 64'd30;
         divisor  = 64'd5;
         step();
         chk("b2b rdy idle", {63'd0, in_ready}, 64'd1);
         step();
         chk("b2b accepted", {63'd0, in_ready}, 64'd0);
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 200) begin
            step();
            lat++;
         end
         chk("b2b lat2", 64'(lat), 64'd65);
         chk("b2b quo2", quotient, 64'd6);
         chk("b2b rem2", remainder, 64'd0);
         step();
      end

      // reset mid-CALC
      begin
         int seen;
         seen       = 0;
         in_valid   = 1'b1;
         div_signed = 1'b1;
         dividend   = -64'sd40;
         divisor    = 64'd6;
         step();
         in_valid = 1'b0;
         repeat (20) step();
         reset = 1'b1;
         step();
         reset = 1'b0;
         chk("mid rst quo", quotient, 64'd0);
         chk("mid rst rem", remainder, 64'd0);
         chk("mid rst rdy", {63'd0, in_ready}, 64'd1);
         for (int k = 0; k < 70; k++) begin
            if (out_valid) seen++;
            step();
         end
         chk("mid rst noov", 64'(seen), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_040978_div_iter.md
Name: ysyx_040978_div_iter

Overview:
- Iterative radix-2 restoring divider; the multi-cycle engine the MDU drives for DIV/DIVU/REM/REMU.
- Accepts one operand pair through an in_valid handshake and returns quotient and remainder together on a single-cycle out_valid pulse.
- Implements RISC-V divide-by-zero and signed-overflow results exactly, so the MDU needs no fix-up logic.

Parameters:
- XLEN, 64, operand and result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid; sampled only in IDLE
- div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned
- dividend  input  XLEN  dividend operand
- divisor  input  XLEN  divisor operand
- flush  input  1  abort any operation in progress; return to IDLE
- in_ready  output  1  high in IDLE only
- out_valid  output  1  one-cycle pulse; results valid
- quotient  output  XLEN  quotient, held until next accept
- remainder  output  XLEN  remainder, held until next accept

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
- Accept: an operand pair is taken when in_valid && state==IDLE && !flush. Operands are captured that cycle; later changes to the inputs are ignored.
- FSM states: IDLE, CALC, DONE.
- IDLE→DONE on accept when the operation is a special case:
  - divisor==0: quotient = all ones, remainder = dividend.
  - div_signed && dividend==1<<(XLEN-1) && divisor==all ones: quotient = dividend, remainder = 0.
  - Latency 1 cycle: out_valid is high the cycle after accept.
- IDLE→CALC on accept otherwise:
  - Latch absolute values: magnitude when div_signed and MSB set, else raw.
  - Latch q_neg = signed && (sign(dividend) xor sign(divisor)).
  - Latch r_neg = signed && sign(dividend).
  - counter = XLEN.
- CALC: one quotient bit per cycle, MSB first.
  - Partial remainder width XLEN+1.
  - Shift {rem,quo} left by 1, trial-subtract the divisor magnitude. If non-negative, keep the difference and set quo[0]=1; else restore.
  - Decrement counter.
  - When counter reaches 1 and that iteration completes, go to DONE and apply sign correction: quotient negated if q_neg, remainder negated if r_neg.
- DONE: out_valid=1 for exactly one cycle, then unconditional →IDLE. in_ready=0 in DONE.
- Latency: normal operation is XLEN+1 cycles from the accept edge to out_valid (65 for XLEN=64).
- in_valid while in CALC/DONE is ignored; no queueing. The caller must hold or reissue in_valid.
- flush:
  - In CALC or DONE: →IDLE next cycle, out_valid forced 0, outputs keep their previous values.
  - Flush on the same cycle as in_valid in IDLE: no accept.
- reset in mid-operation returns to the reset values on the next edge; no partial result is ever presented.
- Back-to-back: a new accept is possible on the cycle after out_valid (IDLE), giving a minimum spacing of XLEN+2 cycles.
- Results are purely combinational from internal registers; there is no output mux on the inputs.

Decomposition:
- Shared package ysyx_040978_mdu_pkg holds:
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - XLEN default;
  - constants INT_MIN and ALL_ONES.
- No sub-module is required. Optional helper ysyx_040978_abs_neg (conditional two's-complement negate, XLEN wide), instantiated for the operand-abs and result-sign paths.

Test Plan:
- Unsigned 100 / 7, div_signed=0 → out_valid exactly 65 cycles after accept; quotient=14, remainder=2.
- Signed -7 / 2 → quotient=-3 (0xFFFF_FFFF_FFFF_FFFD), remainder=-1; signed 7 / -2 → quotient=-3, remainder=1.
- Divide by zero, dividend=0x1234, both signednesses → 1-cycle latency; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
- Signed overflow 0x8000_0000_0000_0000 / -1 → 1-cycle latency; quotient=0x8000_0000_0000_0000, remainder=0. The same operands unsigned take 65 cycles; quotient=0, remainder=0x8000_0000_0000_0000.
- flush at cycle 30 of CALC, with in_valid pulsed at cycle 10 → no out_valid; in_ready=1 the next cycle. A fresh 9/3 then completes with quotient=3, remainder=0.
- Back-to-back accepts with in_valid held high → second accept one cycle after the first out_valid. Also: reset asserted mid-CALC → outputs 0, in_ready=1, no out_valid.
